// File: rtl/mult_col_acc_pkg.sv
// ---------------------------------------------------------------------------
// mult_col_acc_pkg
// Shared constants and types for the column-wise product accumulator that
// sits behind the 128x128 mult core.
//   WORD_W    : result word width (half of a mult product)
//   GUARD_W   : extra accumulator bits above a full product
//   ACC_W     : accumulator width, 2*WORD_W + GUARD_W
//   OPERAND_W : operand width of the surrounding modular multiplier
//   IDX_W     : output word index width
//   state_t   : IDLE / ACC / FLUSH
// ---------------------------------------------------------------------------
package mult_col_acc_pkg;

    localparam int WORD_W    = 128;
    localparam int GUARD_W   = 8;
    localparam int ACC_W     = 2 * WORD_W + GUARD_W;
    localparam int OPERAND_W = 4096;
    // A full product of two OPERAND_W operands spans this many result words.
    localparam int NUM_WORDS = 2 * (OPERAND_W / WORD_W);
    localparam int IDX_W     = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/mult_col_acc.sv
// ---------------------------------------------------------------------------
// mult_col_acc
// Product-scanning accumulator. Sums every 256-bit partial product of one
// result column, emits the low word of the column sum and carries the rest
// into the next column. After the last product a single flush word (the
// remaining carry) is emitted with o_out_last set. No backpressure.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   i_start       : 1-cycle pulse, clears state and enters ACC (aborts)
//   i_p_valid     : partial product present
//   i_p_hi/i_p_lo : upper/lower halves of the product
//   i_p_col_end   : last product of its column (qualified by i_p_valid)
//   i_p_last      : last product of the multiplication
//   o_out_valid   : single-cycle pulse, word/idx/last valid
//   o_out_word    : finished result word
//   o_out_idx     : word index, 0 = least significant
//   o_out_last    : marks the flush word
//   o_busy        : high in ACC or FLUSH
//   o_err         : sticky error, cleared by start or rst
// ---------------------------------------------------------------------------
module mult_col_acc
    import mult_col_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_p_valid,
    input  logic [WORD_W-1:0] i_p_hi,
    input  logic [WORD_W-1:0] i_p_lo,
    input  logic              i_p_col_end,
    input  logic              i_p_last,
    output logic              o_out_valid,
    output logic [WORD_W-1:0] o_out_word,
    output logic [IDX_W-1:0]  o_out_idx,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_err
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_index;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_out_word;
    logic [IDX_W-1:0]   r_out_idx;
    logic               r_out_last;
    logic               r_busy;
    logic               r_err;

    logic [ACC_W-1:0]   w_sum;
    logic               w_col_end;
    logic               w_idx_max;
    logic               w_flush_ovf;

    always_comb begin
        w_sum       = r_acc + ACC_W'({i_p_hi, i_p_lo});
        // A last product always closes its column, flagged or not.
        w_col_end   = i_p_col_end | i_p_last;
        w_idx_max   = (r_index == {IDX_W{1'b1}});
        // Anything left above the flush word cannot be represented.
        w_flush_ovf = (r_acc[ACC_W-1:WORD_W] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_index     <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Emission strobes are pulses; only the cases below raise them.
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;

            if (i_start) begin
                // Start overrides everything, including a product this cycle.
                r_state <= ST_ACC;
                r_acc   <= '0;
                r_index <= '0;
                r_busy  <= 1'b1;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ACC: begin
                        if (i_p_valid) begin
                            if (w_col_end) begin
                                r_out_word  <= w_sum[WORD_W-1:0];
                                r_out_idx   <= r_index;
                                r_out_valid <= 1'b1;
                                r_index     <= r_index + IDX_W'(1);
                                r_acc       <= w_sum >> WORD_W;
                                if (w_idx_max) begin
                                    r_err <= 1'b1;
                                end
                            end else begin
                                r_acc <= w_sum;
                            end
                            if (i_p_last) begin
                                r_state <= ST_FLUSH;
                                if (!i_p_col_end) begin
                                    r_err <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_FLUSH: begin
                        r_out_word  <= r_acc[WORD_W-1:0];
                        r_out_idx   <= r_index;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        // A product arriving now is dropped and flagged.
                        if (w_flush_ovf || i_p_valid) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_index <= '0;
                    end
                    default: begin
                        // IDLE: products are ignored until start.
                    end
                endcase
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_word  = r_out_word;
    assign o_out_idx   = r_out_idx;
    assign o_out_last  = r_out_last;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule

// File: tb/tb_mult_col_acc.sv
module tb_mult_col_acc;

    localparam int W  = 128;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_p_valid = 1'b0;
    logic [W-1:0]  i_p_hi = '0;
    logic [W-1:0]  i_p_lo = '0;
    logic          i_p_col_end = 1'b0;
    logic          i_p_last = 1'b0;
    logic          o_out_valid;
    logic [W-1:0]  o_out_word;
    logic [IW-1:0] o_out_idx;
    logic          o_out_last;
    logic          o_busy;
    logic          o_err;

    mult_col_acc dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_p_valid   (i_p_valid),
        .i_p_hi      (i_p_hi),
        .i_p_lo      (i_p_lo),
        .i_p_col_end (i_p_col_end),
        .i_p_last    (i_p_last),
        .o_out_valid (o_out_valid),
        .o_out_word  (o_out_word),
        .o_out_idx   (o_out_idx),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  word;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [W-1:0] word, input logic [IW-1:0] idx, input logic last);
        exp_t e;
        e.word = word;
        e.idx  = idx;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] hi, input logic [W-1:0] lo,
                        input logic ce, input logic last);
        i_p_hi      = hi;
        i_p_lo      = lo;
        i_p_col_end = ce;
        i_p_last    = last;
        i_p_valid   = 1'b1;
        @(posedge clk);
        #1;
        i_p_valid   = 1'b0;
        i_p_col_end = 1'b0;
        i_p_last    = 1'b0;
    endtask

    // Bounded wait for every expected word to appear.
    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        #1;
        chk(tag, 256'(sb.size()), 256'd0);
    endtask

    // Scoreboard side: compare every emitted word against the queue head.
    always @(negedge clk) begin
        if (!rst && o_out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("out idx=%0d last=%0b word=%0h (expected idx=%0d last=%0b word=%0h)",
                         o_out_idx, o_out_last, o_out_word, e.idx, e.last, e.word);
                chk("out_word", 256'(o_out_word), 256'(e.word));
                chk("out_idx",  256'(o_out_idx),  256'(e.idx));
                chk("out_last", 256'(o_out_last), 256'(e.last));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [W-1:0]   ones;
    logic [W-1:0]   x, a0, a1, b0, b1;
    logic [255:0]   p;
    logic [511:0]   full;

    initial begin
        ones = '1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(o_out_valid), 256'd0);
        chk("rst_out_word",  256'(o_out_word),  256'd0);
        chk("rst_out_idx",   256'(o_out_idx),   256'd0);
        chk("rst_out_last",  256'(o_out_last),  256'd0);
        chk("rst_busy",      256'(o_busy),      256'd0);
        chk("rst_err",       256'(o_err),       256'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- product in IDLE is ignored ----
        send(128'h0, 128'h55, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_busy", 256'(o_busy), 256'd0);

        // ---- single word ----
        pulse_start();
        chk("start_busy", 256'(o_busy), 256'd1);
        push(128'h2, 7'd0, 1'b0);
        push(128'h1, 7'd1, 1'b1);
        send(128'h1, 128'h2, 1'b1, 1'b1);
        drain("single_drain");
        chk("single_err",  256'(o_err),  256'd0);
        chk("single_busy", 256'(o_busy), 256'd0);

        // ---- column carry ----
        pulse_start();
        send(128'h0, ones, 1'b0, 1'b0);
        push({ones[W-1:1], 1'b0}, 7'd0, 1'b0);
        send(128'h0, ones, 1'b1, 1'b0);
        push(128'h1, 7'd1, 1'b0);
        push(128'h0, 7'd2, 1'b1);
        send(128'h0, 128'h0, 1'b1, 1'b1);
        drain("carry_drain");
        chk("carry_err", 256'(o_err), 256'd0);

        // ---- golden 256x256 product ----
        x  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
        a0 = x;
        a1 = ~x;
        b0 = {x[63:0], x[127:64]};
        b1 = x ^ 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
        full = {256'd0, a1, a0} * {256'd0, b1, b0};
        push(full[127:0],   7'd0, 1'b0);
        push(full[255:128], 7'd1, 1'b0);
        push(full[383:256], 7'd2, 1'b0);
        push(full[511:384], 7'd3, 1'b1);
        pulse_start();
        p = {128'd0, a0} * {128'd0, b0};
        send(p[255:128], p[127:0], 1'b1, 1'b0);
        p = {128'd0, a0} * {128'd0, b1};
        send(p[255:128], p[127:0], 1'b0, 1'b0);
        p = {128'd0, a1} * {128'd0, b0};
        send(p[255:128], p[127:0], 1'b1, 1'b0);
        p = {128'd0, a1} * {128'd0, b1};
        send(p[255:128], p[127:0], 1'b1, 1'b1);
        drain("golden_drain");
        chk("golden_err", 256'(o_err), 256'd0);

        // ---- overflow: two all-ones products in one column ----
        pulse_start();
        send(ones, ones, 1'b0, 1'b0);
        push({ones[W-1:1], 1'b0}, 7'd0, 1'b0);
        push(ones, 7'd1, 1'b1);
        send(ones, ones, 1'b1, 1'b1);
        drain("ovf_drain");
        chk("ovf_err", 256'(o_err), 256'd1);
        repeat (4) @(negedge clk);
        chk("ovf_err_sticky", 256'(o_err), 256'd1);
        pulse_start();
        chk("ovf_err_cleared", 256'(o_err), 256'd0);

        // ---- async reset mid-column ----
        send(128'h0, 128'h5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",      256'(o_busy),      256'd0);
        chk("arst_out_valid", 256'(o_out_valid), 256'd0);
        repeat (2) @(negedge clk);
        chk("arst_hold_valid", 256'(o_out_valid), 256'd0);
        rst = 1'b0;

        // ---- start aborts an operation in progress ----
        pulse_start();
        send(128'h0, 128'h7, 1'b0, 1'b0);
        pulse_start();
        push(128'h3, 7'd0, 1'b0);
        push(128'h0, 7'd1, 1'b1);
        send(128'h0, 128'h3, 1'b1, 1'b1);
        drain("abort_drain");
        chk("abort_err", 256'(o_err), 256'd0);

        // ---- product during FLUSH ----
        pulse_start();
        push(128'h9, 7'd0, 1'b0);
        push(128'h0, 7'd1, 1'b1);
        send(128'h0, 128'h9, 1'b1, 1'b1);
        send(128'hff, 128'hff, 1'b1, 1'b0);
        drain("flushp_drain");
        chk("flushp_err", 256'(o_err), 256'd1);

        // ---- index wrap ----
        pulse_start();
        for (int i = 0; i < 127; i++) begin
            push(128'(i + 1), IW'(i), 1'b0);
            send(128'h0, 128'(i + 1), 1'b1, 1'b0);
        end
        chk("wrap_err_before", 256'(o_err), 256'd0);
        push(128'h80, 7'd127, 1'b0);
        send(128'h0, 128'h80, 1'b1, 1'b0);
        #1;
        chk("wrap_err_after", 256'(o_err), 256'd1);
        push(128'h4, 7'd0, 1'b0);
        push(128'h0, 7'd1, 1'b1);
        send(128'h0, 128'h4, 1'b1, 1'b1);
        drain("wrap_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
